// File: rtl/multi_tick_divider.sv
// Bank of independent clock-enable generators sharing MasterClock, each with a
// runtime-programmable divisor, a one-cycle Tick pulse and a toggling Level output.
module multi_tick_divider #(
  parameter int NUM_CHANNELS  = 4,
  parameter int COUNTER_WIDTH = 24,
  parameter int DEFAULT_DIV   = 15000000,
  parameter int CHAN_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                     MasterClock,
  input  logic                     Reset,
  input  logic [NUM_CHANNELS-1:0]  Enable,
  input  logic                     Sync,
  input  logic                     WrEn,
  input  logic [CHAN_W-1:0]        WrChan,
  input  logic [COUNTER_WIDTH-1:0] WrData,
  input  logic [CHAN_W-1:0]        RdChan,
  output logic [COUNTER_WIDTH-1:0] RdDiv,
  output logic [NUM_CHANNELS-1:0]  Tick,
  output logic [NUM_CHANNELS-1:0]  Level
);

  localparam logic [COUNTER_WIDTH-1:0] DEF_DIV = COUNTER_WIDTH'(DEFAULT_DIV);
  localparam logic [COUNTER_WIDTH-1:0] ONE     = COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] count_q [NUM_CHANNELS];
  logic [COUNTER_WIDTH-1:0] count_d [NUM_CHANNELS];
  logic [COUNTER_WIDTH-1:0] div_q   [NUM_CHANNELS];
  logic [COUNTER_WIDTH-1:0] div_d   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]  tick_q, tick_d;
  logic [NUM_CHANNELS-1:0]  level_q, level_d;
  logic [COUNTER_WIDTH-1:0] rd_div_q, rd_div_d;

  // Out-of-range WrChan matches no channel, so such writes fall through harmlessly.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      count_d[i] = count_q[i];
      div_d[i]   = div_q[i];
      tick_d[i]  = 1'b0;
      level_d[i] = level_q[i];
      if (Sync) begin
        count_d[i] = '0;
        level_d[i] = 1'b0;
      end else if (WrEn && (int'(WrChan) == i)) begin
        div_d[i]   = WrData;
        count_d[i] = '0;
      end else if (Enable[i]) begin
        if (count_q[i] == div_q[i]) begin
          count_d[i] = '0;
          tick_d[i]  = 1'b1;
          level_d[i] = ~level_q[i];
        end else begin
          count_d[i] = count_q[i] + ONE;
        end
      end
    end
  end

  // Readback samples the pre-write divisor; a same-cycle write shows up next cycle.
  always_comb begin
    rd_div_d = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (int'(RdChan) == i) rd_div_d = div_q[i];
    end
  end

  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        count_q[i] <= '0;
        div_q[i]   <= DEF_DIV;
      end
      tick_q   <= '0;
      level_q  <= '0;
      rd_div_q <= DEF_DIV;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        count_q[i] <= count_d[i];
        div_q[i]   <= div_d[i];
      end
      tick_q   <= tick_d;
      level_q  <= level_d;
      rd_div_q <= rd_div_d;
    end
  end

  assign RdDiv = rd_div_q;
  assign Tick  = tick_q;
  assign Level = level_q;

endmodule
